// File: rtl/vga_charmem_arbiter.sv
// Shares one single-port character/attribute RAM between the display fetch
// (absolute priority, never stalled) and a 2-entry buffered host requester.
module vga_charmem_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 1024
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              fetch_req_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic [DATA_W-1:0] fetch_rdata_o,
   output logic              fetch_rvalid_o,
   input  logic              host_valid_i,
   output logic              host_ready_o,
   input  logic              host_we_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic [DATA_W-1:0] host_wdata_i,
   input  logic [1:0]        host_be_i,
   output logic [DATA_W-1:0] host_rdata_o,
   output logic              host_rvalid_o,
   output logic              starve_o,
   input  logic              starve_clr_i,
   output logic              ram_en_o,
   output logic [1:0]        ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i
);

   localparam int ENTRY_W = 1 + ADDR_W + DATA_W + 2;
   localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

   logic [ENTRY_W-1:0] fifo_q [2];
   logic               wr_ptr_q, rd_ptr_q;
   logic [1:0]         count_q, count_d;
   logic               ready_q;
   logic               push_s, pop_s, empty_s, stall_s;
   logic               head_we_s;
   logic [ADDR_W-1:0]  head_addr_s;
   logic [DATA_W-1:0]  head_wdata_s;
   logic [1:0]         head_be_s;
   logic               rd_issue_s, rd_owner_s;
   logic               rvalid_q, owner_q;
   logic [DATA_W-1:0]  fetch_hold_q, host_hold_q;
   logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic               starve_q, starve_d, set_s;

   assign empty_s = (count_q == 2'd0);
   assign push_s  = host_valid_i & ready_q;
   assign pop_s   = ~fetch_req_i & ~empty_s;
   assign stall_s = fetch_req_i & ~empty_s;
   assign count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
   assign {head_we_s, head_addr_s, head_wdata_s, head_be_s} = fifo_q[rd_ptr_q];

   assign host_ready_o   = ready_q;
   assign fetch_rvalid_o = rvalid_q & ~owner_q;
   assign host_rvalid_o  = rvalid_q & owner_q;
   assign fetch_rdata_o  = fetch_rvalid_o ? ram_rdata_i : fetch_hold_q;
   assign host_rdata_o   = host_rvalid_o ? ram_rdata_i : host_hold_q;
   assign starve_o       = starve_q;

   // RAM port mux; held idle while reset is asserted so nothing reaches the RAM
   always_comb begin
      ram_en_o    = 1'b0;
      ram_we_o    = 2'b00;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (rst_ni && fetch_req_i) begin
         ram_en_o   = 1'b1;
         ram_addr_o = fetch_addr_i;
      end else if (rst_ni && !empty_s) begin
         ram_en_o    = 1'b1;
         ram_we_o    = head_we_s ? head_be_s : 2'b00;
         ram_addr_o  = head_addr_s;
         ram_wdata_o = head_wdata_s;
      end else begin
         ram_en_o = 1'b0;
      end
   end

   // owner tag: 1 = host read, 0 = fetch read
   always_comb begin
      rd_issue_s = 1'b0;
      rd_owner_s = 1'b0;
      if (fetch_req_i) begin
         rd_issue_s = 1'b1;
      end else if (!empty_s && !head_we_s) begin
         rd_issue_s = 1'b1;
         rd_owner_s = 1'b1;
      end else begin
         rd_issue_s = 1'b0;
      end
   end

   // starvation counter saturates at the limit; the set condition beats a clear
   always_comb begin
      starve_cnt_d = '0;
      if (stall_s) begin
         starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
      end else begin
         starve_cnt_d = '0;
      end
      set_s = stall_s & (starve_cnt_q >= LIMIT_M1);
      if (set_s) begin
         starve_d = 1'b1;
      end else if (starve_clr_i) begin
         starve_d = 1'b0;
      end else begin
         starve_d = starve_q;
      end
   end

   // host request buffer and registered not-full flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         ready_q   <= 1'b1;
      end else begin
         if (push_s) begin
            fifo_q[wr_ptr_q] <= {host_we_i, host_addr_i, host_wdata_i, host_be_i};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
         ready_q <= (count_d != 2'd2);
      end
   end

   // read return tagging, hold registers and starvation state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q     <= 1'b0;
         owner_q      <= 1'b0;
         fetch_hold_q <= '0;
         host_hold_q  <= '0;
         starve_cnt_q <= '0;
         starve_q     <= 1'b0;
      end else begin
         rvalid_q     <= rd_issue_s;
         owner_q      <= rd_owner_s;
         fetch_hold_q <= fetch_rdata_o;
         host_hold_q  <= host_rdata_o;
         starve_cnt_q <= starve_cnt_d;
         starve_q     <= starve_d;
      end
   end

endmodule

// File: tb/tb_vga_charmem_arbiter.sv
// Self-checking bench for vga_charmem_arbiter: behavioural RAM, read-data
// scoreboards, a table of host transactions and hand-written corner sequences.
module tb_vga_charmem_arbiter;
   localparam int AW = 12;
   localparam int DW = 16;
   localparam int SL = 8;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          fetch_req_i;
   logic [AW-1:0] fetch_addr_i;
   logic [DW-1:0] fetch_rdata_o;
   logic          fetch_rvalid_o;
   logic          host_valid_i;
   logic          host_ready_o;
   logic          host_we_i;
   logic [AW-1:0] host_addr_i;
   logic [DW-1:0] host_wdata_i;
   logic [1:0]    host_be_i;
   logic [DW-1:0] host_rdata_o;
   logic          host_rvalid_o;
   logic          starve_o;
   logic          starve_clr_i;
   logic          ram_en_o;
   logic [1:0]    ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [DW-1:0] ram_wdata_o;
   logic [DW-1:0] ram_rdata_i = '0;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ram_mem [0:4095];
   logic [DW-1:0] shadow  [0:4095];
   logic [DW-1:0] fetch_q [$];
   logic [DW-1:0] host_q  [$];
   logic          fetch_d1;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [1:0]    be;
      logic [1:0]    exp_we;
      logic [DW-1:0] exp_rdata;
   } vec_t;
   vec_t vecs [11];

   vga_charmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
      .fetch_rdata_o(fetch_rdata_o), .fetch_rvalid_o(fetch_rvalid_o),
      .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
      .host_we_i(host_we_i), .host_addr_i(host_addr_i),
      .host_wdata_i(host_wdata_i), .host_be_i(host_be_i),
      .host_rdata_o(host_rdata_o), .host_rvalid_o(host_rvalid_o),
      .starve_o(starve_o), .starve_clr_i(starve_clr_i),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s actual=%s required=none", name, what);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // single-port RAM: byte-wise writes, registered read data
   always @(posedge clk_i) begin
      if (ram_en_o) begin
         if (ram_we_o[0]) ram_mem[ram_addr_o][7:0]  <= ram_wdata_o[7:0];
         if (ram_we_o[1]) ram_mem[ram_addr_o][15:8] <= ram_wdata_o[15:8];
         if (ram_we_o == 2'b00) ram_rdata_i <= ram_mem[ram_addr_o];
      end
   end

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) fetch_d1 <= 1'b0;
      else         fetch_d1 <= fetch_req_i;
   end

   always @(posedge clk_i) begin
      if (rst_ni && fetch_req_i) fetch_q.push_back(shadow[fetch_addr_i]);
   end

   // response monitor: fetch latency is fixed, data checked in order
   always @(negedge clk_i) begin
      if (rst_ni) begin
         chk1("fetch_rvalid_latency", fetch_rvalid_o, fetch_d1);
         if (fetch_rvalid_o) begin
            if (fetch_q.size() == 0) fail("fetch_rvalid_unexpected", "pulse");
            else chk16("fetch_rdata", fetch_rdata_o, fetch_q.pop_front());
         end
         if (host_rvalid_o) begin
            if (host_q.size() == 0) fail("host_rvalid_unexpected", "pulse");
            else chk16("host_rdata", host_rdata_o, host_q.pop_front());
         end
      end
   end

   task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [1:0] be, input logic [DW-1:0] exp_rdata);
      bit done = 1'b0;
      host_valid_i = 1'b1;
      host_we_i    = we;
      host_addr_i  = addr;
      host_wdata_i = wdata;
      host_be_i    = be;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk_i);
         if (host_ready_o) begin
            done = 1'b1;
            if (we) begin
               if (be[0]) shadow[addr][7:0]  = wdata[7:0];
               if (be[1]) shadow[addr][15:8] = wdata[15:8];
            end else begin
               host_q.push_back(exp_rdata);
            end
         end
         @(posedge clk_i);
         #1;
      end
      host_valid_i = 1'b0;
      if (!done) fail("host_accept", "timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram_mem[i] = 16'h0000;
         shadow[i]  = 16'h0000;
      end
      ram_mem[0] = 16'h4141; ram_mem[1] = 16'h4242; ram_mem[2] = 16'h4343;
      ram_mem[12'h020] = 16'hFFFF; ram_mem[12'h030] = 16'h1111;
      for (int i = 0; i < 4096; i++) shadow[i] = ram_mem[i];

      vecs[0]  = '{1'b1, 12'h020, 16'h1234, 2'b01, 2'b01, 16'h0000};
      vecs[1]  = '{1'b0, 12'h020, 16'h0000, 2'b00, 2'b00, 16'hFF34};
      vecs[2]  = '{1'b1, 12'h021, 16'hBEEF, 2'b10, 2'b10, 16'h0000};
      vecs[3]  = '{1'b0, 12'h021, 16'h0000, 2'b00, 2'b00, 16'hBE00};
      vecs[4]  = '{1'b1, 12'h030, 16'h5A5A, 2'b00, 2'b00, 16'h0000};
      vecs[5]  = '{1'b0, 12'h030, 16'h0000, 2'b00, 2'b00, 16'h1111};
      vecs[6]  = '{1'b1, 12'h7FF, 16'hC0DE, 2'b11, 2'b11, 16'h0000};
      vecs[7]  = '{1'b0, 12'h7FF, 16'h0000, 2'b00, 2'b00, 16'hC0DE};
      vecs[8]  = '{1'b0, 12'h001, 16'h0000, 2'b00, 2'b00, 16'h4242};
      vecs[9]  = '{1'b1, 12'hFFF, 16'h0F0F, 2'b11, 2'b11, 16'h0000};
      vecs[10] = '{1'b0, 12'hFFF, 16'h0000, 2'b00, 2'b00, 16'h0F0F};

      rst_ni = 1'b0; fetch_req_i = 1'b0; fetch_addr_i = '0; host_valid_i = 1'b0;
      host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0; host_be_i = 2'b00;
      starve_clr_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk1("rst_ready", host_ready_o, 1'b1);
      chk1("rst_ram_en", ram_en_o, 1'b0);
      chk16("rst_ram_we", {14'h0, ram_we_o}, 16'h0000);
      chk1("rst_starve", starve_o, 1'b0);
      chk1("rst_fetch_rvalid", fetch_rvalid_o, 1'b0);
      chk1("rst_host_rvalid", host_rvalid_o, 1'b0);
      chk16("rst_fetch_rdata", fetch_rdata_o, 16'h0000);
      chk16("rst_host_rdata", host_rdata_o, 16'h0000);
      tick();
      rst_ni = 1'b1;
      tick();

      // back-to-back fetch reads
      for (int a = 0; a < 3; a++) begin
         fetch_req_i = 1'b1;
         fetch_addr_i = AW'(a);
         @(negedge clk_i);
         chk1("fetch_ram_en", ram_en_o, 1'b1);
         chk16("fetch_ram_addr", {4'h0, ram_addr_o}, 16'(a));
         chk16("fetch_ram_we", {14'h0, ram_we_o}, 16'h0000);
         tick();
      end
      fetch_req_i = 1'b0;
      repeat (3) tick();

      // host write then read of the same address, cycle-exact
      host_valid_i = 1'b1; host_we_i = 1'b1; host_addr_i = 12'h010;
      host_wdata_i = 16'hABCD; host_be_i = 2'b11;
      @(negedge clk_i);
      chk1("wr_ready", host_ready_o, 1'b1);
      shadow[12'h010] = 16'hABCD;
      tick();
      host_we_i = 1'b0;
      @(negedge clk_i);
      chk1("rd_ready", host_ready_o, 1'b1);
      host_q.push_back(16'hABCD);
      chk1("wr_ram_en", ram_en_o, 1'b1);
      chk16("wr_ram_we", {14'h0, ram_we_o}, 16'h0003);
      chk16("wr_ram_addr", {4'h0, ram_addr_o}, 16'h0010);
      chk16("wr_ram_wdata", ram_wdata_o, 16'hABCD);
      tick();
      host_valid_i = 1'b0;
      @(negedge clk_i);
      chk1("rd_ram_en", ram_en_o, 1'b1);
      chk16("rd_ram_we", {14'h0, ram_we_o}, 16'h0000);
      chk16("rd_ram_addr", {4'h0, ram_addr_o}, 16'h0010);
      chk1("rd_no_early_rvalid", host_rvalid_o, 1'b0);
      tick();
      @(negedge clk_i);
      chk1("rd_rvalid_cycle3", host_rvalid_o, 1'b1);
      chk16("rd_rdata_cycle3", host_rdata_o, 16'hABCD);
      tick();
      @(negedge clk_i);
      chk1("rd_rvalid_single", host_rvalid_o, 1'b0);
      chk16("rd_rdata_hold", host_rdata_o, 16'hABCD);
      tick();

      // table of host transactions with the fetch idle
      for (int i = 0; i < 11; i++) begin
         host_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rdata);
         @(negedge clk_i);
         chk1("vec_ram_en", ram_en_o, 1'b1);
         chk16("vec_ram_we", {14'h0, ram_we_o}, {14'h0, vecs[i].exp_we});
         chk16("vec_ram_addr", {4'h0, ram_addr_o}, {4'h0, vecs[i].addr});
         if (vecs[i].we) chk16("vec_ram_wdata", ram_wdata_o, vecs[i].wdata);
         @(posedge clk_i);
         #1;
      end
      repeat (3) tick();

      // fetch stall fills the buffer; third request is refused
      fetch_req_i = 1'b1; fetch_addr_i = 12'h002;
      host_valid_i = 1'b1; host_we_i = 1'b1; host_be_i = 2'b11;
      host_addr_i = 12'h040; host_wdata_i = 16'h1111;
      @(negedge clk_i);
      chk1("full_ready0", host_ready_o, 1'b1);
      tick();
      host_addr_i = 12'h041; host_wdata_i = 16'h2222;
      @(negedge clk_i);
      chk1("full_ready1", host_ready_o, 1'b1);
      chk16("full_ram_we1", {14'h0, ram_we_o}, 16'h0000);
      tick();
      host_addr_i = 12'h042; host_wdata_i = 16'h3333;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         chk1("full_ready_low", host_ready_o, 1'b0);
         chk16("full_fetch_addr", {4'h0, ram_addr_o}, 16'h0002);
         chk16("full_ram_we", {14'h0, ram_we_o}, 16'h0000);
         tick();
      end
      fetch_req_i = 1'b0; host_valid_i = 1'b0;
      @(negedge clk_i);
      chk16("drain0_we", {14'h0, ram_we_o}, 16'h0003);
      chk16("drain0_addr", {4'h0, ram_addr_o}, 16'h0040);
      chk16("drain0_wdata", ram_wdata_o, 16'h1111);
      tick();
      @(negedge clk_i);
      chk16("drain1_we", {14'h0, ram_we_o}, 16'h0003);
      chk16("drain1_addr", {4'h0, ram_addr_o}, 16'h0041);
      chk16("drain1_wdata", ram_wdata_o, 16'h2222);
      chk1("drain1_ready", host_ready_o, 1'b1);
      tick();
      @(negedge clk_i);
      chk1("drain_idle_en", ram_en_o, 1'b0);
      chk1("drain_no_starve", starve_o, 1'b0);
      shadow[12'h040] = 16'h1111;
      shadow[12'h041] = 16'h2222;
      tick();
      host_op(1'b0, 12'h041, 16'h0000, 2'b00, 16'h2222);
      host_op(1'b0, 12'h042, 16'h0000, 2'b00, 16'h0000);
      repeat (3) tick();

      // starvation: one read held behind 8 fetch cycles, clear vs set
      fetch_req_i = 1'b1; fetch_addr_i = 12'h000;
      host_valid_i = 1'b1; host_we_i = 1'b0; host_addr_i = 12'h010;
      @(negedge clk_i);
      chk1("starve_push_ready", host_ready_o, 1'b1);
      host_q.push_back(16'hABCD);
      tick();
      host_valid_i = 1'b0;
      for (int k = 1; k <= SL; k++) begin
         @(negedge clk_i);
         chk1("starve_not_yet", starve_o, 1'b0);
         chk16("starve_fetch_only", {4'h0, ram_addr_o}, 16'h0000);
         tick();
      end
      starve_clr_i = 1'b1;
      @(negedge clk_i);
      chk1("starve_set", starve_o, 1'b1);
      tick();
      fetch_req_i = 1'b0;
      @(negedge clk_i);
      chk1("starve_set_wins", starve_o, 1'b1);
      chk16("starve_read_issue", {4'h0, ram_addr_o}, 16'h0010);
      tick();
      starve_clr_i = 1'b0;
      @(negedge clk_i);
      chk1("starve_cleared", starve_o, 1'b0);
      chk1("starve_read_done", host_rvalid_o, 1'b1);
      repeat (3) tick();

      // reset with two writes buffered behind the fetch
      fetch_req_i = 1'b1; fetch_addr_i = 12'h001;
      host_valid_i = 1'b1; host_we_i = 1'b1; host_be_i = 2'b11;
      host_addr_i = 12'h050; host_wdata_i = 16'hDEAD;
      tick();
      host_addr_i = 12'h051; host_wdata_i = 16'hBEEF;
      tick();
      host_valid_i = 1'b0;
      @(negedge clk_i);
      chk1("prerst_full", host_ready_o, 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      chk1("midrst_ready", host_ready_o, 1'b1);
      chk1("midrst_ram_en", ram_en_o, 1'b0);
      chk16("midrst_ram_we", {14'h0, ram_we_o}, 16'h0000);
      chk1("midrst_fetch_rvalid", fetch_rvalid_o, 1'b0);
      chk1("midrst_host_rvalid", host_rvalid_o, 1'b0);
      chk16("midrst_host_rdata", host_rdata_o, 16'h0000);
      fetch_req_i = 1'b0;
      tick();
      fetch_q.delete();
      host_q.delete();
      rst_ni = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         chk1("postrst_ram_en", ram_en_o, 1'b0);
         chk1("postrst_ready", host_ready_o, 1'b1);
         tick();
      end
      host_op(1'b0, 12'h050, 16'h0000, 2'b00, 16'h0000);
      host_op(1'b0, 12'h051, 16'h0000, 2'b00, 16'h0000);
      repeat (4) tick();

      chk16("host_queue_drained", 16'(host_q.size()), 16'h0000);
      chk16("fetch_queue_drained", 16'(fetch_q.size()), 16'h0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
